inj_seq_core: RTL

Bus-programmable injection sequencer that emits a train of single-cycle start strobes into the pulse-generator core's external start input, driving charge-injection scans. Sits directly upstream of the pulse generator on the same 8-bit register bus. Programmable initial delay, period and count, with optional hold-off while the downstream generator is still busy. Software trigger or external trigger.

---
 rtl/inj_seq_core.sv | 334 +++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/inj_seq_core.sv
// inj_seq_core: bus-programmable injection sequencer.
// Emits a train of one-cycle INJ_START strobes after a programmable delay,
// spaced by a programmable period, for a programmable count (0 = endless).
// Optional build macro: INJ_SEQ_FIRED_CNT_EN
//   defined   -> addresses 13/14 read the live fired counter and 15/16 read a
//                saturating HOLD-cycle counter
//   undefined -> addresses 13..16 read 0 and the HOLD counter is not built
module inj_seq_core #(
    parameter int ABUSWIDTH = 16
) (
    input  logic                 BUS_CLK,
    input  logic                 BUS_RST,
    input  logic [ABUSWIDTH-1:0] BUS_ADD,
    input  logic [7:0]           BUS_DATA_IN,
    output logic [7:0]           BUS_DATA_OUT,
    input  logic                 BUS_WR,
    input  logic                 BUS_RD,
    input  logic                 EXT_TRIGGER,
    input  logic                 INJ_BUSY,
    output logic                 INJ_START,
    output logic                 GATE
);

    localparam logic [7:0] VERSION = 8'd1;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_WAIT_DELAY  = 3'd1,
        ST_FIRE        = 3'd2,
        ST_WAIT_PERIOD = 3'd3,
        ST_HOLD        = 3'd4,
        ST_DONE        = 3'd5
    } state_t;

    // A zero period behaves as a period of one cycle.
    function automatic logic [31:0] period_eff(input logic [31:0] period);
        if (period == 32'd0) begin
            period_eff = 32'd1;
        end else begin
            period_eff = period;
        end
    endfunction

    // Bus decode
    logic       addr_ok_s;
    logic [4:0] reg_idx_s;
    logic       soft_rst_s;
    logic       rst_s;
    logic       wr_ctrl_s;
    logic       stop_s;
    logic       sw_start_s;
    logic       ext_start_s;
    logic       start_go_s;

    // Configuration registers
    logic        conf_en_r;
    logic        conf_wait_busy_r;
    logic [31:0] conf_delay_r;
    logic [31:0] conf_period_r;
    logic [15:0] conf_num_r;

    // Sequencer state
    state_t      state_r;
    state_t      state_nxt_s;
    logic [31:0] cnt_r;
    logic [31:0] cnt_nxt_s;
    logic [15:0] fired_r;
    logic [15:0] fired_nxt_s;
    logic [31:0] period_sh_r;
    logic [31:0] period_sh_nxt_s;
    logic [15:0] num_sh_r;
    logic [15:0] num_sh_nxt_s;
    logic        gate_r;
    logic        gate_nxt_s;
    logic        done_r;
    logic        done_nxt_s;
    logic        inj_start_r;
    logic        inj_start_nxt_s;
    logic        fire_s;
    logic        last_fire_s;
    logic        hold_req_s;
    logic        ext_prev_r;

    // Read path
    logic [7:0]  rd_data_s;
    logic [7:0]  data_out_r;

`ifdef INJ_SEQ_FIRED_CNT_EN
    logic [15:0] hold_cnt_r;
`endif

    // Registers live in the low 5 address bits; anything above must be zero.
    assign addr_ok_s  = (BUS_ADD[ABUSWIDTH-1:5] == '0);
    assign reg_idx_s  = BUS_ADD[4:0];

    // Any write to address 0 is a soft reset equivalent to BUS_RST.
    assign soft_rst_s = BUS_WR && addr_ok_s && (reg_idx_s == 5'd0);
    assign rst_s      = BUS_RST || soft_rst_s;

    // Control register: bit1 stop has priority over bit0 start.
    assign wr_ctrl_s  = BUS_WR && addr_ok_s && (reg_idx_s == 5'd1);
    assign stop_s     = wr_ctrl_s && BUS_DATA_IN[1];
    assign sw_start_s = wr_ctrl_s && BUS_DATA_IN[0] && !BUS_DATA_IN[1];

    // External trigger only starts an idle, armed sequencer on a rising edge.
    assign ext_start_s = EXT_TRIGGER && !ext_prev_r && conf_en_r && (state_r == ST_IDLE);
    assign start_go_s  = (sw_start_s || ext_start_s) && !stop_s;

    // Sequence ends on the strobe that brings the fired count up to a non-zero NUM.
    assign last_fire_s = (fired_r == num_sh_r) && (num_sh_r != 16'd0);
    assign hold_req_s  = conf_wait_busy_r && INJ_BUSY;

    // One-register rising-edge detector for EXT_TRIGGER
    always_ff @(posedge BUS_CLK) begin
        if (rst_s) begin
            ext_prev_r <= 1'b0;
        end else begin
            ext_prev_r <= EXT_TRIGGER;
        end
    end

    // Configuration registers written from the bus
    always_ff @(posedge BUS_CLK) begin
        if (rst_s) begin
            conf_en_r        <= 1'b0;
            conf_wait_busy_r <= 1'b0;
            conf_delay_r     <= 32'd0;
            conf_period_r    <= 32'd1;
            conf_num_r       <= 16'd1;
        end else if (BUS_WR && addr_ok_s) begin
            case (reg_idx_s)
                5'd2: begin
                    conf_en_r        <= BUS_DATA_IN[0];
                    conf_wait_busy_r <= BUS_DATA_IN[1];
                end
                5'd3:  conf_delay_r[7:0]    <= BUS_DATA_IN;
                5'd4:  conf_delay_r[15:8]   <= BUS_DATA_IN;
                5'd5:  conf_delay_r[23:16]  <= BUS_DATA_IN;
                5'd6:  conf_delay_r[31:24]  <= BUS_DATA_IN;
                5'd7:  conf_period_r[7:0]   <= BUS_DATA_IN;
                5'd8:  conf_period_r[15:8]  <= BUS_DATA_IN;
                5'd9:  conf_period_r[23:16] <= BUS_DATA_IN;
                5'd10: conf_period_r[31:24] <= BUS_DATA_IN;
                5'd11: conf_num_r[7:0]      <= BUS_DATA_IN;
                5'd12: conf_num_r[15:8]     <= BUS_DATA_IN;
                default: begin
                    conf_en_r <= conf_en_r;
                end
            endcase
        end else begin
            conf_en_r <= conf_en_r;
        end
    end

    // Next-state and next-output logic of the sequencer
    always_comb begin
        state_nxt_s     = state_r;
        cnt_nxt_s       = cnt_r;
        fired_nxt_s     = fired_r;
        gate_nxt_s      = gate_r;
        done_nxt_s      = done_r;
        inj_start_nxt_s = 1'b0;
        period_sh_nxt_s = period_sh_r;
        num_sh_nxt_s    = num_sh_r;
        fire_s          = 1'b0;

        if (stop_s) begin
            state_nxt_s = ST_IDLE;
            gate_nxt_s  = 1'b0;
            done_nxt_s  = 1'b1;
        end else if (start_go_s) begin
            // Latch the configuration so later bus writes leave this run alone.
            state_nxt_s     = ST_WAIT_DELAY;
            cnt_nxt_s       = conf_delay_r;
            period_sh_nxt_s = conf_period_r;
            num_sh_nxt_s    = conf_num_r;
            fired_nxt_s     = 16'd0;
            gate_nxt_s      = 1'b1;
            done_nxt_s      = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_nxt_s = ST_IDLE;
                end
                ST_WAIT_DELAY: begin
                    if (cnt_r == 32'd0) begin
                        fire_s = 1'b1;
                    end else begin
                        cnt_nxt_s = cnt_r - 32'd1;
                    end
                end
                ST_FIRE: begin
                    if (last_fire_s) begin
                        state_nxt_s = ST_DONE;
                        gate_nxt_s  = 1'b0;
                        done_nxt_s  = 1'b1;
                    end else if (cnt_r <= 32'd1) begin
                        // Period of one: the next strobe is due right now.
                        if (hold_req_s) begin
                            state_nxt_s = ST_HOLD;
                        end else begin
                            fire_s = 1'b1;
                        end
                    end else begin
                        cnt_nxt_s   = cnt_r - 32'd1;
                        state_nxt_s = ST_WAIT_PERIOD;
                    end
                end
                ST_WAIT_PERIOD: begin
                    if (cnt_r <= 32'd1) begin
                        if (hold_req_s) begin
                            state_nxt_s = ST_HOLD;
                        end else begin
                            fire_s = 1'b1;
                        end
                    end else begin
                        cnt_nxt_s = cnt_r - 32'd1;
                    end
                end
                ST_HOLD: begin
                    if (!INJ_BUSY) begin
                        fire_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_HOLD;
                    end
                end
                ST_DONE: begin
                    state_nxt_s = ST_IDLE;
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    gate_nxt_s  = 1'b0;
                    done_nxt_s  = 1'b1;
                end
            endcase

            // A strobe reloads the period counter so the next one lands exactly
            // max(PERIOD,1) edges later.
            if (fire_s) begin
                state_nxt_s     = ST_FIRE;
                inj_start_nxt_s = 1'b1;
                fired_nxt_s     = fired_r + 16'd1;
                cnt_nxt_s       = period_eff(period_sh_r);
            end else begin
                inj_start_nxt_s = 1'b0;
            end
        end
    end

    // Sequencer state and registered outputs
    always_ff @(posedge BUS_CLK) begin
        if (rst_s) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 32'd0;
            fired_r     <= 16'd0;
            period_sh_r <= 32'd1;
            num_sh_r    <= 16'd1;
            gate_r      <= 1'b0;
            done_r      <= 1'b1;
            inj_start_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            fired_r     <= fired_nxt_s;
            period_sh_r <= period_sh_nxt_s;
            num_sh_r    <= num_sh_nxt_s;
            gate_r      <= gate_nxt_s;
            done_r      <= done_nxt_s;
            inj_start_r <= inj_start_nxt_s;
        end
    end

`ifdef INJ_SEQ_FIRED_CNT_EN
    // Saturating count of cycles spent waiting in HOLD, cleared on start
    always_ff @(posedge BUS_CLK) begin
        if (rst_s) begin
            hold_cnt_r <= 16'd0;
        end else if (start_go_s) begin
            hold_cnt_r <= 16'd0;
        end else if (!stop_s && (state_r == ST_HOLD) && (hold_cnt_r != 16'hFFFF)) begin
            hold_cnt_r <= hold_cnt_r + 16'd1;
        end else begin
            hold_cnt_r <= hold_cnt_r;
        end
    end
`endif

    // Read data multiplexer
    always_comb begin
        rd_data_s = 8'd0;
        if (addr_ok_s) begin
            case (reg_idx_s)
                5'd0:  rd_data_s = VERSION;
                5'd1:  rd_data_s = {6'd0, gate_r, done_r};
                5'd2:  rd_data_s = {6'd0, conf_wait_busy_r, conf_en_r};
                5'd3:  rd_data_s = conf_delay_r[7:0];
                5'd4:  rd_data_s = conf_delay_r[15:8];
                5'd5:  rd_data_s = conf_delay_r[23:16];
                5'd6:  rd_data_s = conf_delay_r[31:24];
                5'd7:  rd_data_s = conf_period_r[7:0];
                5'd8:  rd_data_s = conf_period_r[15:8];
                5'd9:  rd_data_s = conf_period_r[23:16];
                5'd10: rd_data_s = conf_period_r[31:24];
                5'd11: rd_data_s = conf_num_r[7:0];
                5'd12: rd_data_s = conf_num_r[15:8];
`ifdef INJ_SEQ_FIRED_CNT_EN
                5'd13: rd_data_s = fired_r[7:0];
                5'd14: rd_data_s = fired_r[15:8];
                5'd15: rd_data_s = hold_cnt_r[7:0];
                5'd16: rd_data_s = hold_cnt_r[15:8];
`endif
                default: rd_data_s = 8'd0;
            endcase
        end else begin
            rd_data_s = 8'd0;
        end
    end

    // Registered read data, updated only on a read strobe
    always_ff @(posedge BUS_CLK) begin
        if (rst_s) begin
            data_out_r <= 8'd0;
        end else if (BUS_RD) begin
            data_out_r <= rd_data_s;
        end else begin
            data_out_r <= data_out_r;
        end
    end

    assign BUS_DATA_OUT = data_out_r;
    assign INJ_START    = inj_start_r;
    assign GATE         = gate_r;

endmodule
